// File: rtl/bsg_manycore_link_to_axil_rx_mc.sv
// bsg_manycore_link_to_axil_rx_mc: serializes per-channel link words into AXI-lite beats, round-robin at word granularity.
// Define BSG_MANYCORE_LINK_TO_AXIL_RX_MC_WORD_COUNT_EN to add per-channel completed-word counters on word_count_o.
module bsg_manycore_link_to_axil_rx_mc #(
    parameter int axil_data_width_p = 32,
    parameter int fifo_width_p      = 128,
    parameter int num_ch_p          = 2,
    parameter int depth_p           = 2,
    localparam int ratio_lp = fifo_width_p / axil_data_width_p,
    localparam int cw_lp    = $clog2(ratio_lp * depth_p + 1),
    localparam int chw_lp   = (num_ch_p > 1) ? $clog2(num_ch_p) : 1
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_ch_p*fifo_width_p-1:0] fifo_req_i,
    input  logic [num_ch_p-1:0]              fifo_req_v_i,
    output logic [num_ch_p-1:0]              fifo_req_ready_o,
    output logic [axil_data_width_p-1:0]     axil_req_o,
    output logic [chw_lp-1:0]                axil_req_ch_o,
    output logic                             axil_req_last_o,
    output logic                             axil_req_v_o,
    input  logic                             axil_req_ready_i,
    output logic [num_ch_p*cw_lp-1:0]        req_credits_o
`ifdef BSG_MANYCORE_LINK_TO_AXIL_RX_MC_WORD_COUNT_EN
    ,
    output logic [num_ch_p*32-1:0]           word_count_o
`endif
);
    localparam int bd_lp = ratio_lp * depth_p;
    localparam int bw_lp = (ratio_lp > 1) ? $clog2(ratio_lp) : 1;
    localparam int pw_lp = (bd_lp > 1) ? $clog2(bd_lp) : 1;

    typedef enum logic {S_IDLE, S_LOCK} arb_t;

    logic [num_ch_p-1:0]          w_empty, w_full, w_wr, w_pop;
    logic [axil_data_width_p-1:0] w_head [num_ch_p];
    arb_t                         r_state, w_state_n;
    logic [chw_lp-1:0]            r_lock_ch, r_prio, w_gnt, w_ch;
    logic [bw_lp-1:0]             r_beat;
    logic                         w_any, w_v, w_last, w_fire;
    int                           w_idx;

    if (ratio_lp * axil_data_width_p != fifo_width_p || num_ch_p < 1 || depth_p < 1) begin : g_bad_cfg
        $fatal(1, "bsg_manycore_link_to_axil_rx_mc: illegal parameter combination");
    end

    genvar c;
    for (c = 0; c < num_ch_p; c++) begin : g_ch
        logic [fifo_width_p-1:0]      r_ser;
        logic [bw_lp-1:0]             r_ser_cnt;
        logic                         r_ser_v;
        logic [axil_data_width_p-1:0] r_mem [bd_lp];
        logic [pw_lp-1:0]             r_wp, r_rp;
        logic [cw_lp-1:0]             r_cnt;
        logic                         w_ser_last, w_acc;

        assign w_ser_last = (r_ser_cnt == bw_lp'(ratio_lp - 1));
        assign w_full[c]  = (r_cnt == cw_lp'(bd_lp));
        assign w_empty[c] = (r_cnt == '0);
        assign w_wr[c]    = r_ser_v & ~w_full[c];
        assign fifo_req_ready_o[c] = ~r_ser_v | (w_wr[c] & w_ser_last);
        assign w_acc      = fifo_req_v_i[c] & fifo_req_ready_o[c];
        assign w_head[c]  = r_mem[r_rp];
        assign req_credits_o[c*cw_lp +: cw_lp] = cw_lp'(bd_lp) - r_cnt;

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                r_ser     <= '0;
                r_ser_v   <= 1'b0;
                r_ser_cnt <= '0;
                r_wp      <= '0;
                r_rp      <= '0;
                r_cnt     <= '0;
            end else begin
                if (w_acc) begin
                    r_ser     <= fifo_req_i[c*fifo_width_p +: fifo_width_p];
                    r_ser_v   <= 1'b1;
                    r_ser_cnt <= '0;
                end else if (w_wr[c]) begin
                    // shift so the next beat is always in the low slice
                    r_ser     <= r_ser >> axil_data_width_p;
                    r_ser_v   <= ~w_ser_last;
                    r_ser_cnt <= r_ser_cnt + 1'b1;
                end
                if (w_wr[c])
                    r_wp <= (r_wp == pw_lp'(bd_lp - 1)) ? '0 : r_wp + 1'b1;
                if (w_pop[c])
                    r_rp <= (r_rp == pw_lp'(bd_lp - 1)) ? '0 : r_rp + 1'b1;
                r_cnt <= r_cnt + cw_lp'(w_wr[c]) - cw_lp'(w_pop[c]);
            end
        end

        always_ff @(posedge clk_i) begin
            if (w_wr[c])
                r_mem[r_wp] <= r_ser[axil_data_width_p-1:0];
        end
    end

    always_comb begin
        w_gnt = r_prio;
        w_any = 1'b0;
        w_idx = 0;
        for (int i = 0; i < num_ch_p; i++) begin
            w_idx = int'(r_prio) + i;
            if (w_idx >= num_ch_p)
                w_idx = w_idx - num_ch_p;
            if (!w_any && !w_empty[w_idx]) begin
                w_gnt = chw_lp'(w_idx);
                w_any = 1'b1;
            end
        end
    end

    // a presented beat 0 locks the grant so the offered beat cannot change before its handshake
    assign w_ch   = (r_state == S_LOCK) ? r_lock_ch : w_gnt;
    assign w_v    = (r_state == S_LOCK) ? ~w_empty[r_lock_ch] : w_any;
    assign w_last = (r_beat == bw_lp'(ratio_lp - 1));
    assign w_fire = w_v & axil_req_ready_i;
    assign w_pop  = w_fire ? (num_ch_p'(1) << w_ch) : '0;

    assign axil_req_v_o    = w_v;
    assign axil_req_ch_o   = w_ch;
    assign axil_req_last_o = w_v & w_last;
    assign axil_req_o      = w_head[w_ch];

    always_comb begin
        w_state_n = r_state;
        if (w_fire && w_last)
            w_state_n = S_IDLE;
        else if (w_v)
            w_state_n = S_LOCK;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= S_IDLE;
            r_lock_ch <= '0;
            r_prio    <= '0;
            r_beat    <= '0;
        end else begin
            r_state   <= w_state_n;
            r_lock_ch <= w_ch;
            if (w_fire) begin
                r_beat <= w_last ? '0 : r_beat + 1'b1;
                if (w_last)
                    r_prio <= (w_ch == chw_lp'(num_ch_p - 1)) ? '0 : w_ch + 1'b1;
            end
        end
    end

`ifdef BSG_MANYCORE_LINK_TO_AXIL_RX_MC_WORD_COUNT_EN
    for (c = 0; c < num_ch_p; c++) begin : g_wc
        logic [31:0] r_wc;
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i)
                r_wc <= '0;
            else if (w_fire && w_last && w_ch == chw_lp'(c))
                r_wc <= r_wc + 1'b1;
        end
        assign word_count_o[c*32 +: 32] = r_wc;
    end
`endif
endmodule

// File: tb/tb_bsg_manycore_link_to_axil_rx_mc.sv
// tb_bsg_manycore_link_to_axil_rx_mc: randomized and directed checks of the link-to-AXI-lite receive path
// against a word-level model (per-channel word queues, LS slice first, round-robin at word granularity).
module tb_bsg_manycore_link_to_axil_rx_mc;
    logic         clk = 1'b0;
    logic         reset_i;
    logic [255:0] fifo_req_i;
    logic [1:0]   fifo_req_v_i;
    logic [1:0]   fifo_req_ready_o;
    logic [31:0]  axil_req_o;
    logic         axil_req_ch_o;
    logic         axil_req_last_o;
    logic         axil_req_v_o;
    logic         axil_req_ready_i;
    logic [7:0]   req_credits_o;
`ifdef BSG_MANYCORE_LINK_TO_AXIL_RX_MC_WORD_COUNT_EN
    logic [63:0]  word_count_o;
`endif

    always #5 clk = ~clk;

    bsg_manycore_link_to_axil_rx_mc dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .fifo_req_i(fifo_req_i),
        .fifo_req_v_i(fifo_req_v_i),
        .fifo_req_ready_o(fifo_req_ready_o),
        .axil_req_o(axil_req_o),
        .axil_req_ch_o(axil_req_ch_o),
        .axil_req_last_o(axil_req_last_o),
        .axil_req_v_o(axil_req_v_o),
        .axil_req_ready_i(axil_req_ready_i),
        .req_credits_o(req_credits_o)
`ifdef BSG_MANYCORE_LINK_TO_AXIL_RX_MC_WORD_COUNT_EN
        ,
        .word_count_o(word_count_o)
`endif
    );

    typedef struct packed {logic [31:0] d; logic ch; logic last;} beat_t;

    int           vectors = 0;
    int           miscompares = 0;
    int           rmode = 0;
    logic [127:0] send_q [2][$];
    logic [127:0] acc_q [2][$];
    beat_t        obs_q [$];

    function automatic logic [31:0] slice(input logic [127:0] w, input int b);
        return w[b*32 +: 32];
    endfunction

    function automatic logic [127:0] rword();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic bit idle();
        return send_q[0].size() == 0 && send_q[1].size() == 0 && !axil_req_v_o &&
               fifo_req_ready_o == 2'b11 && req_credits_o == 8'h88;
    endfunction

    // one clock: drive at the falling edge, then log the handshakes the next rising edge will take
    task automatic cyc();
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            fifo_req_v_i[c] = send_q[c].size() > 0;
            fifo_req_i[c*128 +: 128] = (send_q[c].size() > 0) ? send_q[c][0] : 128'(0);
        end
        axil_req_ready_i = (rmode == 0) ? 1'b0 : (rmode == 1) ? 1'b1 :
                           (rmode == 2) ? 1'($urandom()) : ~axil_req_ready_i;
        #1;
        if (axil_req_v_o && axil_req_ready_i)
            obs_q.push_back({axil_req_o, axil_req_ch_o, axil_req_last_o});
        for (int c = 0; c < 2; c++)
            if (fifo_req_v_i[c] && fifo_req_ready_o[c])
                acc_q[c].push_back(send_q[c].pop_front());
    endtask

    task automatic drain(input int budget, output bit ok);
        int n = 0;
        do begin
            cyc();
            n++;
        end while (!idle() && n < budget);
        ok = idle();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        fifo_req_v_i = '0;
        axil_req_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            send_q[c].delete();
            acc_q[c].delete();
        end
        obs_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({axil_req_v_o, axil_req_last_o, axil_req_ch_o, fifo_req_ready_o, req_credits_o} !== {3'b000, 2'b11, 8'h88}) begin
            $display("FAIL reset_during got v/last/ch/rdy/cr=%b/%b/%b/%b/%h want 0/0/0/11/88",
                     axil_req_v_o, axil_req_last_o, axil_req_ch_o, fifo_req_ready_o, req_credits_o);
            miscompares++;
        end
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        vectors++;
        if ({axil_req_v_o, axil_req_last_o, axil_req_ch_o, fifo_req_ready_o, req_credits_o} !== {3'b000, 2'b11, 8'h88}) begin
            $display("FAIL reset_after got v/last/ch/rdy/cr=%b/%b/%b/%b/%h want 0/0/0/11/88",
                     axil_req_v_o, axil_req_last_o, axil_req_ch_o, fifo_req_ready_o, req_credits_o);
            miscompares++;
        end
    endtask

    task automatic test_single_word();
        logic [127:0] w = 128'h44443333_22221111_DDDDCCCC_BBBBAAAA;
        int   exp_cr [6] = '{8, 7, 7, 7, 7, 8};
        logic exp_v [6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        rmode = 1;
        send_q[0].push_back(w);
        cyc();
        vectors++;
        if (acc_q[0].size() != 1) begin
            $display("FAIL single_accept got %0d words want 1", acc_q[0].size());
            miscompares++;
        end
        for (int i = 0; i < 6; i++) begin
            cyc();
            vectors++;
            if ({axil_req_v_o, req_credits_o[3:0]} !== {exp_v[i], 4'(exp_cr[i])}) begin
                $display("FAIL single_cyc%0d got v=%b cr0=%0d want v=%b cr0=%0d",
                         i, axil_req_v_o, req_credits_o[3:0], exp_v[i], exp_cr[i]);
                miscompares++;
            end
            if (i == 0) begin
                vectors++;
                if (fifo_req_ready_o[0] !== 1'b0) begin
                    $display("FAIL single_busy_ready got %b want 0", fifo_req_ready_o[0]);
                    miscompares++;
                end
            end
        end
        vectors++;
        if (obs_q.size() != 4) begin
            $display("FAIL single_nbeats got %0d want 4", obs_q.size());
            miscompares++;
        end
        for (int b = 0; b < 4 && b < obs_q.size(); b++) begin
            vectors++;
            if (obs_q[b] !== {slice(w, b), 1'b0, b == 3}) begin
                $display("FAIL single_beat%0d got %h want %h", b, obs_q[b], {slice(w, b), 1'b0, b == 3});
                miscompares++;
            end
        end
    endtask

    task automatic test_both_channels(input int mode, input string tag);
        logic [127:0] wl [4];
        logic         prev_v, prev_ch, prev_last, hold;
        logic [31:0]  prev_d;
        int           n = 0;
        do_reset();
        rmode = mode;
        for (int k = 0; k < 4; k++) begin
            wl[k] = rword();
            send_q[k % 2].push_back(wl[k]);
        end
        hold = 1'b0;
        {prev_v, prev_ch, prev_last, prev_d} = '0;
        do begin
            cyc();
            n++;
            if (hold) begin
                vectors++;
                if ({axil_req_v_o, axil_req_ch_o, axil_req_last_o, axil_req_o} !== {prev_v, prev_ch, prev_last, prev_d}) begin
                    $display("FAIL %s_hold got v/ch/last/d=%b/%b/%b/%h want %b/%b/%b/%h", tag,
                             axil_req_v_o, axil_req_ch_o, axil_req_last_o, axil_req_o, prev_v, prev_ch, prev_last, prev_d);
                    miscompares++;
                end
            end
            hold = axil_req_v_o && !axil_req_ready_i;
            {prev_v, prev_ch, prev_last, prev_d} = {axil_req_v_o, axil_req_ch_o, axil_req_last_o, axil_req_o};
        end while (!idle() && n < 200);
        vectors++;
        if (!idle() || obs_q.size() != 16) begin
            $display("FAIL %s_drain got %0d beats idle=%b want 16 beats idle=1", tag, obs_q.size(), idle());
            miscompares++;
        end
        for (int k = 0; k < 16 && k < obs_q.size(); k++) begin
            vectors++;
            if (obs_q[k] !== {slice(wl[k/4], k % 4), 1'(k / 4 % 2), k % 4 == 3}) begin
                $display("FAIL %s_order%0d got %h want %h", tag, k, obs_q[k],
                         {slice(wl[k/4], k % 4), 1'(k / 4 % 2), k % 4 == 3});
                miscompares++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] w [3];
        logic [127:0] x;
        logic [127:0] ord [4];
        logic         och [4];
        bit           ok;
        do_reset();
        rmode = 0;
        for (int k = 0; k < 3; k++) begin
            w[k] = rword();
            send_q[1].push_back(w[k]);
        end
        repeat (14) cyc();
        vectors++;
        if ({req_credits_o[7:4], fifo_req_ready_o[1], axil_req_v_o, axil_req_ch_o} !== {4'd0, 1'b0, 1'b1, 1'b1}) begin
            $display("FAIL bp_full got cr1=%0d rdy1=%b v=%b ch=%b want 0/0/1/1",
                     req_credits_o[7:4], fifo_req_ready_o[1], axil_req_v_o, axil_req_ch_o);
            miscompares++;
        end
        x = rword();
        send_q[0].push_back(x);
        repeat (6) cyc();
        vectors++;
        if (acc_q[0].size() != 1 || req_credits_o[3:0] !== 4'd4) begin
            $display("FAIL bp_independent got acc0=%0d cr0=%0d want 1/4", acc_q[0].size(), req_credits_o[3:0]);
            miscompares++;
        end
        rmode = 1;
        drain(200, ok);
        vectors++;
        if (!ok || obs_q.size() != 16) begin
            $display("FAIL bp_drain got %0d beats idle=%b want 16 beats idle=1", obs_q.size(), ok);
            miscompares++;
        end
        ord = '{w[0], x, w[1], w[2]};
        och = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 16 && k < obs_q.size(); k++) begin
            vectors++;
            if (obs_q[k] !== {slice(ord[k/4], k % 4), och[k/4], k % 4 == 3}) begin
                $display("FAIL bp_order%0d got %h want %h", k, obs_q[k], {slice(ord[k/4], k % 4), och[k/4], k % 4 == 3});
                miscompares++;
            end
        end
    endtask

    task automatic test_reset_mid_word();
        logic [127:0] y;
        bit           ok;
        int           n = 0;
        do_reset();
        rmode = 1;
        send_q[0].push_back(rword());
        send_q[1].push_back(rword());
        while (obs_q.size() < 2 && n < 20) begin
            cyc();
            n++;
        end
        @(posedge clk);
        #2;
        reset_i = 1'b1;
        fifo_req_v_i = '0;
        #1;
        vectors++;
        if ({axil_req_v_o, axil_req_last_o, axil_req_ch_o, fifo_req_ready_o, req_credits_o} !== {3'b000, 2'b11, 8'h88}) begin
            $display("FAIL rst_mid got v/last/ch/rdy/cr=%b/%b/%b/%b/%h want 0/0/0/11/88",
                     axil_req_v_o, axil_req_last_o, axil_req_ch_o, fifo_req_ready_o, req_credits_o);
            miscompares++;
        end
        @(posedge clk);
        #2;
        reset_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            send_q[c].delete();
            acc_q[c].delete();
        end
        obs_q.delete();
        y = rword();
        send_q[1].push_back(y);
        cyc();
        vectors++;
        if (acc_q[1].size() != 1) begin
            $display("FAIL rst_first_accept got %0d words want 1", acc_q[1].size());
            miscompares++;
        end
        drain(50, ok);
        vectors++;
        if (!ok || obs_q.size() != 4) begin
            $display("FAIL rst_post_drain got %0d beats idle=%b want 4 beats idle=1", obs_q.size(), ok);
            miscompares++;
        end
        for (int b = 0; b < 4 && b < obs_q.size(); b++) begin
            vectors++;
            if (obs_q[b] !== {slice(y, b), 1'b1, b == 3}) begin
                $display("FAIL rst_post_beat%0d got %h want %h", b, obs_q[b], {slice(y, b), 1'b1, b == 3});
                miscompares++;
            end
        end
    endtask

    task automatic test_random();
        int   wi [2] = '{0, 0};
        int   bi [2] = '{0, 0};
        int   open_ch = -1;
        int   n = 0;
        int   ch;
        do_reset();
        rmode = 2;
        for (int k = 0; k < 40; k++)
            send_q[$urandom_range(0, 1)].push_back(rword());
        do begin
            cyc();
            n++;
            vectors++;
            if (req_credits_o[3:0] > 4'd8 || req_credits_o[7:4] > 4'd8) begin
                $display("FAIL rnd_credit_range got %h want both <= 8", req_credits_o);
                miscompares++;
            end
        end while (!idle() && n < 3000);
        vectors++;
        if (!idle()) begin
            $display("FAIL rnd_drain got busy after %0d cycles want idle", n);
            miscompares++;
        end
        foreach (obs_q[k]) begin
            ch = int'(obs_q[k].ch);
            vectors++;
            if (open_ch >= 0 && open_ch != ch) begin
                $display("FAIL rnd_interleave at beat %0d got ch %0d want ch %0d", k, ch, open_ch);
                miscompares++;
            end
            vectors++;
            if (wi[ch] >= acc_q[ch].size() ||
                obs_q[k] !== {slice(acc_q[ch][wi[ch]], bi[ch]), 1'(ch), bi[ch] == 3}) begin
                $display("FAIL rnd_beat%0d got %h want ch%0d word %0d beat %0d", k, obs_q[k], ch, wi[ch], bi[ch]);
                miscompares++;
            end
            open_ch = (bi[ch] == 3) ? -1 : ch;
            wi[ch] += (bi[ch] == 3);
            bi[ch] = (bi[ch] + 1) % 4;
        end
        vectors++;
        if (wi[0] != acc_q[0].size() || wi[1] != acc_q[1].size() || acc_q[0].size() + acc_q[1].size() != 40) begin
            $display("FAIL rnd_complete got words %0d/%0d of %0d/%0d want all of 40",
                     wi[0], wi[1], acc_q[0].size(), acc_q[1].size());
            miscompares++;
        end
    endtask

`ifdef BSG_MANYCORE_LINK_TO_AXIL_RX_MC_WORD_COUNT_EN
    task automatic test_word_count();
        bit ok;
        do_reset();
        rmode = 2;
        repeat (5) send_q[1].push_back(rword());
        drain(300, ok);
        vectors++;
        if (!ok || word_count_o !== {32'd5, 32'd0}) begin
            $display("FAIL word_count got %0d/%0d idle=%b want 0/5 idle=1",
                     word_count_o[31:0], word_count_o[63:32], ok);
            miscompares++;
        end
    endtask
`endif

    initial begin
        reset_i = 1'b1;
        fifo_req_i = '0;
        fifo_req_v_i = '0;
        axil_req_ready_i = 1'b0;
        test_reset();
        test_single_word();
        test_both_channels(1, "both");
        test_both_channels(3, "stall");
        test_backpressure();
        test_reset_mid_word();
        test_random();
`ifdef BSG_MANYCORE_LINK_TO_AXIL_RX_MC_WORD_COUNT_EN
        test_word_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
